// File: rtl/alu_pkg.sv
// Shared opcodes, widths and payload types for the ALU command sequencer.
package alu_pkg;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned FLAG_W = 1;
    localparam int unsigned OP_W   = 3;

    typedef enum logic [OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_INC = 3'b010,
        OP_DEC = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_NOT = 3'b111
    } alu_op_e;

    typedef struct packed {
        alu_op_e             op;
        logic                use_acc;
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
    } alu_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_STALL = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_core.sv
// Combinational 4-bit ALU: arithmetic ops report carry/borrow in c, logic ops clear it.
module alu_core
    import alu_pkg::*;
(
    input  alu_op_e           op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] y,
    output logic [FLAG_W-1:0] c
);

    logic [DATA_W:0] wide;

    // One extra bit holds carry out (add) or borrow (subtract wraps to bit DATA_W).
    always_comb begin
        wide = '0;
        case (op)
            OP_ADD:  wide = {1'b0, a} + {1'b0, b};
            OP_SUB:  wide = {1'b0, a} - {1'b0, b};
            OP_INC:  wide = {1'b0, a} + (DATA_W+1)'(1);
            OP_DEC:  wide = {1'b0, a} - (DATA_W+1)'(1);
            OP_AND:  wide = {1'b0, a & b};
            OP_OR:   wide = {1'b0, a | b};
            OP_XOR:  wide = {1'b0, a ^ b};
            OP_NOT:  wide = {1'b0, ~a};
            default: wide = '0;
        endcase
    end

    assign y = wide[DATA_W-1:0];
    assign c = FLAG_W'(wide[DATA_W]);

endmodule

// File: rtl/alu_cmd_seq.sv
// Command FIFO feeding the ALU, with an accumulator and a registered response slot.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_use_acc,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_y,
    output logic [FLAG_W-1:0] rsp_c,
    output logic              rsp_z
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    alu_cmd_t          mem_q [DEPTH];
    alu_cmd_t          mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_y_q, rsp_y_d;
    logic [FLAG_W-1:0] rsp_c_q, rsp_c_d;
    logic              rsp_z_q, rsp_z_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    seq_state_e        state_q, state_d;

    alu_cmd_t          head;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] alu_y;
    logic [FLAG_W-1:0] alu_c;
    logic              push;
    logic              exec;

    // Head operand selection: accumulator already holds the previous execute's result.
    assign head = mem_q[rd_ptr_q];
    assign op_a = head.use_acc ? acc_q : head.a;
    assign push = cmd_valid && cmd_ready_q;
    assign exec = (count_q != '0) && (!rsp_valid_q || rsp_ready);

    alu_core u_alu_core (
        .op (head.op),
        .a  (op_a),
        .b  (head.b),
        .y  (alu_y),
        .c  (alu_c)
    );

    // Next-state logic for FIFO, response slot, accumulator and sequencer state.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rsp_valid_d = rsp_valid_q;
        rsp_y_d     = rsp_y_q;
        rsp_c_d     = rsp_c_q;
        rsp_z_d     = rsp_z_q;
        acc_d       = acc_q;
        state_d     = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = '{op: alu_op_e'(cmd_op), use_acc: cmd_use_acc, a: cmd_a, b: cmd_b};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end

        if (exec) begin
            rd_ptr_d    = rd_ptr_q + PTR_W'(1);
            rsp_valid_d = 1'b1;
            rsp_y_d     = alu_y;
            rsp_c_d     = alu_c;
            rsp_z_d     = (alu_y == '0);
            acc_d       = alu_y;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        if (push && !exec) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && exec) begin
            count_d = count_q - CNT_W'(1);
        end

        case (state_q)
            ST_IDLE: state_d = push ? ST_BUSY : ST_IDLE;
            default: begin
                if ((count_d == '0) && !rsp_valid_d) begin
                    state_d = ST_IDLE;
                end else if (rsp_valid_d && !exec && (count_d != '0)) begin
                    state_d = ST_STALL;
                end else begin
                    state_d = ST_BUSY;
                end
            end
        endcase

        if (clr) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            rsp_valid_d = 1'b0;
            rsp_y_d     = '0;
            rsp_c_d     = '0;
            rsp_z_d     = 1'b1;
            acc_d       = '0;
            state_d     = ST_IDLE;
        end

        cmd_ready_d = (count_d < CNT_W'(DEPTH));
    end

    // State registers with asynchronous flush on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_c_q     <= '0;
            rsp_z_q     <= 1'b1;
            acc_q       <= '0;
            state_q     <= ST_IDLE;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            rsp_c_q     <= rsp_c_d;
            rsp_z_q     <= rsp_z_d;
            acc_q       <= acc_d;
            state_q     <= state_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_z     = rsp_z_q;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed bench for alu_cmd_seq with hand-computed expected responses.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'b000;
    logic [3:0] cmd_a = 4'h0;
    logic [3:0] cmd_b = 4'h0;
    logic       cmd_use_acc = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_y;
    logic       rsp_c;
    logic       rsp_z;

    int checks = 0;
    int errors = 0;

    alu_cmd_seq #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr         (clr),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_use_acc (cmd_use_acc),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_y       (rsp_y),
        .rsp_c       (rsp_c),
        .rsp_z       (rsp_z)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [3:0] y,
                           input logic c, input logic z);
        chk({tag, ".valid"}, 8'(rsp_valid), 8'(v));
        chk({tag, ".y"},     8'(rsp_y),     8'(y));
        chk({tag, ".c"},     8'(rsp_c),     8'(c));
        chk({tag, ".z"},     8'(rsp_z),     8'(z));
    endtask

    task automatic offer(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic use_acc);
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = use_acc;
        cmd_valid   = 1'b1;
    endtask

    initial begin
        // Reset state
        #3 rst_n = 1'b0;
        #1;
        chk_rsp("reset", 1'b0, 4'h0, 1'b0, 1'b1);
        chk("reset.ready", 8'(cmd_ready), 8'd1);
        tick();
        tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // ADD 9+8: one-cycle latency, carry out
        offer(OP_ADD, 4'h9, 4'h8, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("add.latency", 8'(rsp_valid), 8'd0);
        tick();
        chk_rsp("add", 1'b1, 4'h1, 1'b1, 1'b0);
        tick();
        chk("add.drain", 8'(rsp_valid), 8'd0);

        // SUB 3-5 then DEC 0: borrow on both
        offer(OP_SUB, 4'h3, 4'h5, 1'b0);
        tick();
        offer(OP_DEC, 4'h0, 4'h0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk_rsp("sub", 1'b1, 4'hE, 1'b1, 1'b0);
        tick();
        chk_rsp("dec", 1'b1, 4'hF, 1'b1, 1'b0);
        tick();
        chk("dec.drain", 8'(rsp_valid), 8'd0);

        // INC F then ADD acc+1, then NOT 5
        offer(OP_INC, 4'hF, 4'h0, 1'b0);
        tick();
        offer(OP_ADD, 4'h7, 4'h1, 1'b1);
        tick();
        offer(OP_NOT, 4'h5, 4'h0, 1'b0);
        chk_rsp("inc", 1'b1, 4'h0, 1'b1, 1'b1);
        tick();
        cmd_valid = 1'b0;
        chk_rsp("addacc", 1'b1, 4'h1, 1'b0, 1'b0);
        tick();
        chk_rsp("not", 1'b1, 4'hA, 1'b0, 1'b0);
        tick();
        chk("not.drain", 8'(rsp_valid), 8'd0);

        // Backpressure: five commands fill the response slot plus four FIFO entries
        rsp_ready = 1'b0;
        offer(OP_ADD, 4'h1, 4'h1, 1'b0);
        tick();
        offer(OP_SUB, 4'h7, 4'h2, 1'b0);
        tick();
        offer(OP_AND, 4'hC, 4'hA, 1'b0);
        tick();
        offer(OP_OR, 4'h5, 4'h2, 1'b0);
        tick();
        chk("bp.ready4", 8'(cmd_ready), 8'd1);
        offer(OP_XOR, 4'hF, 4'h3, 1'b0);
        tick();
        chk("bp.full", 8'(cmd_ready), 8'd0);
        chk_rsp("bp.hold1", 1'b1, 4'h2, 1'b0, 1'b0);
        offer(OP_NOT, 4'h0, 4'h0, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk("bp.full2", 8'(cmd_ready), 8'd0);
        chk_rsp("bp.hold2", 1'b1, 4'h2, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        tick();
        chk_rsp("bp.r1", 1'b1, 4'h5, 1'b0, 1'b0);
        chk("bp.ready_back", 8'(cmd_ready), 8'd1);
        tick();
        chk_rsp("bp.r2", 1'b1, 4'h8, 1'b0, 1'b0);
        tick();
        chk_rsp("bp.r3", 1'b1, 4'h7, 1'b0, 1'b0);
        tick();
        chk_rsp("bp.r4", 1'b1, 4'hC, 1'b0, 1'b0);
        tick();
        chk("bp.drain", 8'(rsp_valid), 8'd0);

        // clr with a full FIFO and a command offered
        rsp_ready = 1'b0;
        offer(OP_ADD, 4'h1, 4'h2, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("clr.full", 8'(cmd_ready), 8'd0);
        offer(OP_NOT, 4'h0, 4'h0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        chk_rsp("clr", 1'b0, 4'h0, 1'b0, 1'b1);
        chk("clr.ready", 8'(cmd_ready), 8'd1);
        tick();
        chk("clr.lost1", 8'(rsp_valid), 8'd0);
        tick();
        chk("clr.lost2", 8'(rsp_valid), 8'd0);
        offer(OP_OR, 4'hF, 4'h0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_rsp("clr.acc", 1'b1, 4'h0, 1'b0, 1'b1);
        tick();

        // Reset mid-operation with three commands queued behind a held response
        rsp_ready = 1'b0;
        offer(OP_ADD, 4'h5, 4'h5, 1'b0);
        tick();
        offer(OP_SUB, 4'h9, 4'h1, 1'b0);
        tick();
        offer(OP_AND, 4'hF, 4'hF, 1'b0);
        tick();
        offer(OP_XOR, 4'h1, 4'h1, 1'b0);
        tick();
        cmd_valid = 1'b0;
        chk_rsp("rst.pre", 1'b1, 4'hA, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk_rsp("rst.now", 1'b0, 4'h0, 1'b0, 1'b1);
        chk("rst.ready", 8'(cmd_ready), 8'd1);
        rsp_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst.quiet", 8'(rsp_valid), 8'd0);
        end
        offer(OP_OR, 4'hF, 4'h0, 1'b1);
        tick();
        cmd_valid = 1'b0;
        tick();
        chk_rsp("rst.acc", 1'b1, 4'h0, 1'b0, 1'b1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
